// File: rtl/param_stream_pkg.sv
// rtl/param_stream_pkg.sv - shared state type and sizing helpers for the parameter ROM streamer
package param_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  // Two spare entries over the ROM latency keep full rate despite the non-crediting issue check
  function automatic int fifo_depth_f(input int read_latency);
    return read_latency + 2;
  endfunction

  function automatic int cnt_width_f(input int max_value);
    return (max_value < 2) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/param_stream_skid_fifo.sv
// rtl/param_stream_skid_fifo.sv - register FIFO with show-ahead head, absorbs ROM words under backpressure
module param_stream_skid_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             empty
);

  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/param_rom_stream_ctrl.sv
// rtl/param_rom_stream_ctrl.sv - streams a parameter ROM tensor N passes per start over valid/ready
// Optional PARAM_STREAM_PERF_EN adds stall_cycles and run_cycles counters.
module param_rom_stream_ctrl
  import param_stream_pkg::*;
#(
  parameter int DATA_WIDTH   = 512,
  parameter int DEPTH        = 32,
  parameter int ADDR_WIDTH   = $clog2(DEPTH) + 1,
  parameter int READ_LATENCY = 2,
  parameter int REPEAT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [REPEAT_WIDTH-1:0] repeat_count,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   rom_addr,
  output logic                    rom_ce,
  input  logic [DATA_WIDTH-1:0]   rom_q,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    data_out_valid,
  input  logic                    data_out_ready
`ifdef PARAM_STREAM_PERF_EN
  ,
  output logic [31:0]             stall_cycles,
  output logic [31:0]             run_cycles
`endif
);

  localparam int FIFO_DEPTH = fifo_depth_f(READ_LATENCY);
  localparam int CW         = cnt_width_f(FIFO_DEPTH + READ_LATENCY);

  state_t                  state;
  state_t                  state_next;
  logic [READ_LATENCY-1:0] issue_sr;
  logic [CW-1:0]           inflight;
  logic [CW-1:0]           fifo_count;
  logic [REPEAT_WIDTH-1:0] pass_left;
  logic                    fifo_empty;
  logic                    fifo_push;
  logic                    issue;
  logic                    addr_wrap;
  logic                    last_issue;
  logic                    start_accept;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CW'(issue_sr[i]);
  end

  // Pops in the same cycle are deliberately not credited, so the FIFO can never overflow
  assign issue      = (state == STREAM) && ((inflight + fifo_count) < CW'(FIFO_DEPTH));
  assign addr_wrap  = (rom_addr == ADDR_WIDTH'(DEPTH - 1));
  assign last_issue = issue && addr_wrap && (pass_left == REPEAT_WIDTH'(1));
  assign fifo_push  = issue_sr[READ_LATENCY-1];

  assign busy           = (state != IDLE);
  assign rom_ce         = (state != IDLE);
  assign data_out_valid = !fifo_empty;

  always_comb begin
    state_next   = state;
    done         = 1'b0;
    start_accept = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_accept = 1'b1;
          state_next   = STREAM;
        end
      end
      STREAM: begin
        if (last_issue) state_next = DRAIN;
      end
      DRAIN: begin
        if ((inflight == '0) && fifo_empty) begin
          done = 1'b1;
          if (start) begin
            start_accept = 1'b1;
            state_next   = STREAM;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rom_addr  <= '0;
      pass_left <= '0;
      issue_sr  <= '0;
    end else begin
      state       <= state_next;
      issue_sr[0] <= issue;
      for (int i = 1; i < READ_LATENCY; i++) issue_sr[i] <= issue_sr[i-1];
      if (start_accept) begin
        rom_addr  <= '0;
        pass_left <= (repeat_count == '0) ? REPEAT_WIDTH'(1) : repeat_count;
      end else if (issue) begin
        if (addr_wrap) begin
          rom_addr  <= '0;
          pass_left <= pass_left - 1'b1;
        end else begin
          rom_addr <= rom_addr + 1'b1;
        end
      end
    end
  end

  param_stream_skid_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (rom_q),
    .pop       (data_out_ready),
    .head      (data_out),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

`ifdef PARAM_STREAM_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      run_cycles   <= '0;
    end else if (start_accept) begin
      stall_cycles <= '0;
      run_cycles   <= '0;
    end else begin
      if (data_out_valid && !data_out_ready && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
      if (state != IDLE) run_cycles <= run_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_param_rom_stream_ctrl.sv
// tb/tb_param_rom_stream_ctrl.sv - scoreboard bench for param_rom_stream_ctrl with a behavioural ROM
module tb_param_rom_stream_ctrl;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH) + 1;
  localparam int RL    = 2;
  localparam int RW    = 8;
  localparam int FD    = RL + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [RW-1:0] repeat_count;
  logic          busy;
  logic          done;
  logic [AW-1:0] rom_addr;
  logic          rom_ce;
  logic [DW-1:0] rom_q;
  logic [DW-1:0] data_out;
  logic          data_out_valid;
  logic          data_out_ready;
`ifdef PARAM_STREAM_PERF_EN
  logic [31:0]   stall_cycles;
  logic [31:0]   run_cycles;
`endif

  param_rom_stream_ctrl #(
    .DATA_WIDTH   (DW),
    .DEPTH        (DEPTH),
    .ADDR_WIDTH   (AW),
    .READ_LATENCY (RL),
    .REPEAT_WIDTH (RW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .repeat_count   (repeat_count),
    .busy           (busy),
    .done           (done),
    .rom_addr       (rom_addr),
    .rom_ce         (rom_ce),
    .rom_q          (rom_q),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready)
`ifdef PARAM_STREAM_PERF_EN
    ,
    .stall_cycles   (stall_cycles),
    .run_cycles     (run_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] rom_word(input int a);
    return DW'(17 * a);
  endfunction

  // ROM: registered, RL-cycle latency, advances only while ce is high
  logic [DW-1:0] rom_pipe [RL];
  always @(posedge clk) begin
    if (rom_ce) begin
      rom_pipe[0] <= rom_word(int'(rom_addr));
      for (int i = 1; i < RL; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
  end
  assign rom_q = rom_pipe[RL-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  logic [DW-1:0] exp_q [$];
  int            run_len_q [$];
  int            beats_in_run = 0;
  int            done_cnt = 0;
  int            first_acc = 0;
  int            last_acc = 0;
  int            span_last = 0;
  int            stall_seen = 0;
  int            t_done = 0;
  int            t_start = 0;
  int            ready_mode = 0;

  initial begin
    data_out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: data_out_ready = 1'b1;
        1: data_out_ready = ~data_out_ready;
        2: data_out_ready = 1'($urandom_range(0, 1));
        default: ;
      endcase
    end
  end

  // Monitor: pops the scoreboard on each accepted beat, checks hold and done timing
  initial begin
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", 64'(data_out_valid), 64'(1));
          check("hold_data", 64'(data_out), 64'(prev_data));
        end
        if (dut.fifo_push)
          check("no_overflow", 64'(dut.fifo_count == 3'(FD) && !(data_out_valid && data_out_ready)), 64'(0));
        if (data_out_valid && data_out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat actual=0x%0h expected=none", data_out);
          end else begin
            check("beat", 64'(data_out), 64'(exp_q.pop_front()));
          end
          if (beats_in_run == 0) first_acc = cyc;
          last_acc = cyc;
          beats_in_run++;
        end
        if (data_out_valid && !data_out_ready) stall_seen++;
        if (done) begin
          done_cnt++;
          t_done    = cyc;
          span_last = last_acc - first_acc;
          if (run_len_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=1 expected=0");
          end else begin
            check("run_len", 64'(beats_in_run), 64'(run_len_q.pop_front()));
            check("done_after_last", 64'(cyc), 64'(last_acc + 1));
          end
          beats_in_run = 0;
        end
        prev_stall = data_out_valid && !data_out_ready;
        prev_data  = data_out;
      end
    end
  end

  task automatic expect_run(input int rc);
    int passes;
    passes = (rc == 0) ? 1 : rc;
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < DEPTH; i++) exp_q.push_back(rom_word(i));
    run_len_q.push_back(passes * DEPTH);
  endtask

  task automatic launch(input int rc);
    int k;
    expect_run(rc);
    @(posedge clk);
    #1;
    start        = 1'b1;
    repeat_count = RW'(rc);
    @(posedge clk);
    #1;
    start   = 1'b0;
    t_start = cyc;
    k = 0;
    while (!data_out_valid && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("first_valid_latency", 64'(k), 64'(RL + 1));
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 3000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (done_cnt < target) begin
      errors++;
      $display("FAIL wait_done_timeout actual=%0d expected=%0d", done_cnt, target);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_valid"}, 64'(data_out_valid), 64'(0));
    check({tag, "_rom_ce"}, 64'(rom_ce), 64'(0));
    check({tag, "_rom_addr"}, 64'(rom_addr), 64'(0));
    check({tag, "_data_out"}, 64'(data_out), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int d0;
    int n;
    int rc;
    logic [AW-1:0] a1;
    rst          = 1'b1;
    start        = 1'b0;
    repeat_count = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // single pass at full rate
    ready_mode = 0;
    d0 = done_cnt;
    launch(1);
    wait_done(d0 + 1);
    check("t1_consecutive_span", 64'(span_last), 64'(DEPTH - 1));

    // three passes with ready toggling
    ready_mode = 1;
    d0 = done_cnt;
    launch(3);
    wait_done(d0 + 1);

    // long backpressure mid-pass
    ready_mode     = 3;
    data_out_ready = 1'b1;
    d0 = done_cnt;
    launch(2);
    n = 0;
    while (beats_in_run < 2 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    data_out_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    a1 = rom_addr;
    repeat (10) @(posedge clk);
    #1;
    check("t3_fifo_full", 64'(dut.fifo_count), 64'(FD));
    check("t3_issue_halted", 64'(rom_addr), 64'(a1));
    check("t3_still_busy", 64'(busy), 64'(1));
    data_out_ready = 1'b1;
    wait_done(d0 + 1);

    // repeat_count 0 is one pass; start while busy is ignored
    ready_mode = 0;
    d0 = done_cnt;
    launch(0);
    start        = 1'b1;
    repeat_count = RW'(5);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(d0 + 1);
    repeat (20) @(posedge clk);
    #1;
    check("t4_idle_after", 64'(busy), 64'(0));
    check("t4_single_done", 64'(done_cnt), 64'(d0 + 1));
    check("t4_queue_empty", 64'(exp_q.size()), 64'(0));

    // start held high: ignored while busy, accepted in the done cycle
    ready_mode = 2;
    d0 = done_cnt;
    expect_run(2);
    expect_run(2);
    @(posedge clk);
    #1;
    start        = 1'b1;
    repeat_count = RW'(2);
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    check("b2b_no_gap", 64'(busy), 64'(1));
    wait_done(d0 + 2);

    // randomized runs
    for (int it = 0; it < 4; it++) begin
      ready_mode = $urandom_range(0, 2);
      rc = $urandom_range(0, 3);
      d0 = done_cnt;
      launch(rc);
      wait_done(d0 + 1);
    end

    // asynchronous reset mid pass 2
    ready_mode = 2;
    d0 = done_cnt;
    launch(3);
    n = 0;
    while (beats_in_run < DEPTH + 1 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("abort");
    exp_q.delete();
    run_len_q.delete();
    beats_in_run = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_cnt), 64'(d0));
    ready_mode = 0;
    launch(1);
    wait_done(d0 + 1);

`ifdef PARAM_STREAM_PERF_EN
    ready_mode     = 3;
    data_out_ready = 1'b1;
    stall_seen     = 0;
    d0 = done_cnt;
    launch(1);
    data_out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    data_out_ready = 1'b1;
    wait_done(d0 + 1);
    check("perf_stall_seen", 64'(stall_seen), 64'(5));
    check("perf_stall_cycles", 64'(stall_cycles), 64'(5));
    check("perf_run_cycles", 64'(run_cycles), 64'(t_done - t_start + 1));
`endif

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
